eh2_lsu_amo_ctl: RTL and testbench
==================================

// Module: eh2_lsu_amo_ctl
// PURPOSE
//  Sequencer/arbiter for the LSU atomic read-modify-write datapath, shared by all hardware threads.
//  Arbitrates per-thread atomic requests (LR, SC, AMO*), reads memory, drives the AMO ALU,
//  writes the result back, and returns the old memory value.
//  Holds one LR reservation per thread and implements SC success/failure.
//  Sits between the per-thread LSU issue logic and the DCCM read/write port.
// PARAMETERS
//  NUM_THREADS  2  number of requesting threads (1..2); tid width = 1
// PORTS
//  clk             in   1        core clock
//  rst             in   1        synchronous, active-high reset
//  req_valid       in   NT       per-thread atomic request valid
//  req_ready       out  NT       per-thread accept; handshake completes when valid&ready
//  req_addr        in   NT*32    per-thread word address ([1:0] ignored)
//  req_op          in   NT*5     atomic_instr[4:0]: 0 add, 1 swap, 2 LR, 3 SC, 4 xor, 8 or, 12 and, 16 min, 20 max, 24 minu, 28 maxu
//  req_unsign      in   NT       unsigned compare for min/max
//  req_data        in   NT*32    store operand
//  mem_rd_req      out  1        memory read strobe, 1-cycle pulse
//  mem_addr        out  32       address for read and write, {addr[31:2],2'b0}
//  mem_rd_valid    in   1        read data returned
//  mem_rd_data     in   32       corrected read data
//  mem_rd_err      in   1        uncorrectable error, qualified by mem_rd_valid
//  mem_wr_req      out  1        write request; held until mem_wr_ack
//  mem_wr_data     out  32       write data
//  mem_wr_ack      in   1        write accepted
//  alu_op          out  5        opcode to AMO ALU
//  alu_unsign      out  1        unsigned flag to AMO ALU
//  alu_mem_data    out  32       memory operand to AMO ALU
//  alu_st_data     out  32       store operand to AMO ALU
//  alu_result      in   32       combinational AMO ALU result
//  snoop_wr_valid  in   1        any other store committing to memory
//  snoop_wr_addr   in   32       address of that store
//  rsp_valid       out  NT       one-hot, 1-cycle response pulse
//  rsp_data        out  32       old mem value (AMO/LR); 0 = SC success, 1 = SC fail
//  rsp_err         out  1        response carries read error
//  busy            out  1        FSM not in IDLE
// BEHAVIOUR
//  Reset: FSM=IDLE; rr pointer=0; all reservations invalid.
//   All outputs 0 except req_ready, which is 1 for every thread.
//  FSM: IDLE -> RD -> WAIT -> EXEC -> WR -> RSP -> IDLE.
//  IDLE: req_ready=1 for all threads.
//   Grant goes to the valid thread at/after the rr pointer; the pointer then moves to grant+1.
//   Latch tid, addr, op, unsign, data. Go to RD; req_ready=0 outside IDLE.
//  SC in IDLE:
//   - reservation[tid] valid and addr[31:2] matches: go to WR with mem_wr_data=req_data.
//   - otherwise: go to RSP with rsp_data=1, and make no memory access.
//   - reservation[tid] is cleared in both cases.
//  RD: mem_rd_req=1 for one cycle, then WAIT. WAIT holds until mem_rd_valid; rd_data is latched.
//  WAIT, rd_err: go to RSP with rsp_err=1 and rsp_data=0. No write; reservation unchanged.
//  WAIT, LR: set reservation[tid]={1,addr[31:2]}, then go to RSP with rsp_data=rd_data.
//  WAIT, AMO: go to EXEC.
//  EXEC, 1 cycle: drive the ALU with the latched operands, register alu_result into wr_data, go to WR.
//   alu_* outputs are 0 in all other states.
//  WR: mem_wr_req stays asserted until mem_wr_ack. In the ack cycle:
//   - every thread's reservation matching addr[31:2] is cleared;
//   - go to RSP. rsp_data is rd_data for AMO and 0 for a successful SC.
//  RSP: rsp_valid[tid]=1 for exactly one cycle, then IDLE. There is no response backpressure.
//  Snoop: snoop_wr_valid clears any reservation whose address matches snoop_wr_addr[31:2], in any state.
//   Same-cycle snoop and LR set on the same address: the clear wins.
//  Unknown op: treated as swap.
//  Reset mid-operation: abort immediately. Pending mem_wr_req drops; no response; reservations cleared.
//  Latency, no wait states: AMO = 6 cycles from accept to rsp_valid, LR = 4, SC-pass = 3, SC-fail = 2.
// TESTING
//  amoadd: mem[0x100]=5, T0 data=3 -> mem written 8, rsp_valid[0], rsp_data=5, 6 cycles.
//  amomin signed: mem=0xFFFFFFFF, data=1 -> write 0xFFFFFFFF. amominu, same operands -> write 1.
//  LR/SC: T0 LR 0x200, then T0 SC 0x200 data=7 -> mem=7, rsp=0. Repeat SC -> rsp=1, no write.
//  Snoop/cross-thread: T0 LR 0x200; snoop or T1 amoswap writes 0x200 -> T0 SC rsp=1, no mem_wr_req.
//  Arbitration: T0 and T1 valid every cycle -> grants alternate T0,T1,T0. A single thread gets back-to-back grants.
//  mem_rd_err on amoor -> rsp_err=1, rsp_data=0, no mem_wr_req. Reset asserted in WR -> wr_req=0 next cycle, busy=0.

Source files
------------

// File: rtl/eh2_lsu_amo_ctl_if.sv
// Bundle of the atomic controller's thread-request, memory-port, AMO-ALU, snoop and response signals.
// master = the controller, slave = the surrounding LSU/DCCM/ALU environment.
interface eh2_lsu_amo_ctl_if #(
  parameter int NT = 2
);
  logic [NT-1:0]       req_valid;
  logic [NT-1:0]       req_ready;
  logic [NT-1:0][31:0] req_addr;
  logic [NT-1:0][4:0]  req_op;
  logic [NT-1:0]       req_unsign;
  logic [NT-1:0][31:0] req_data;
  logic                mem_rd_req;
  logic [31:0]         mem_addr;
  logic                mem_rd_valid;
  logic [31:0]         mem_rd_data;
  logic                mem_rd_err;
  logic                mem_wr_req;
  logic [31:0]         mem_wr_data;
  logic                mem_wr_ack;
  logic [4:0]          alu_op;
  logic                alu_unsign;
  logic [31:0]         alu_mem_data;
  logic [31:0]         alu_st_data;
  logic [31:0]         alu_result;
  logic                snoop_wr_valid;
  logic [31:0]         snoop_wr_addr;
  logic [NT-1:0]       rsp_valid;
  logic [31:0]         rsp_data;
  logic                rsp_err;
  logic                busy;

  modport master (
    input  req_valid, req_addr, req_op, req_unsign, req_data,
    input  mem_rd_valid, mem_rd_data, mem_rd_err, mem_wr_ack,
    input  alu_result, snoop_wr_valid, snoop_wr_addr,
    output req_ready, mem_rd_req, mem_addr, mem_wr_req, mem_wr_data,
    output alu_op, alu_unsign, alu_mem_data, alu_st_data,
    output rsp_valid, rsp_data, rsp_err, busy
  );

  modport slave (
    output req_valid, req_addr, req_op, req_unsign, req_data,
    output mem_rd_valid, mem_rd_data, mem_rd_err, mem_wr_ack,
    output alu_result, snoop_wr_valid, snoop_wr_addr,
    input  req_ready, mem_rd_req, mem_addr, mem_wr_req, mem_wr_data,
    input  alu_op, alu_unsign, alu_mem_data, alu_st_data,
    input  rsp_valid, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/eh2_lsu_amo_ctl.sv
// Shared LR/SC/AMO sequencer: round-robin thread arbitration, read -> ALU -> write-back,
// per-thread LR reservations with snoop invalidation, and a one-cycle response pulse.
module eh2_lsu_amo_ctl #(
  parameter int NUM_THREADS = 2
) (
  input  logic              clk,
  input  logic              rst,
  eh2_lsu_amo_ctl_if.master bus,
  output logic [2:0]        o_dbg_state
);
  localparam int NT = NUM_THREADS;
  localparam int TW = (NT > 1) ? $clog2(NT) : 1;
  localparam logic [4:0] OP_SWAP = 5'd1;
  localparam logic [4:0] OP_LR   = 5'd2;
  localparam logic [4:0] OP_SC   = 5'd3;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_EXEC, S_WR, S_RSP} state_e;

  state_e              r_state;
  logic [TW-1:0]       r_rr;
  logic [TW-1:0]       r_tid;
  logic [31:0]         r_addr;
  logic [4:0]          r_op;
  logic                r_unsign;
  logic [31:0]         r_data;
  logic [31:0]         r_rd_data;
  logic                r_mem_rd_req;
  logic                r_mem_wr_req;
  logic [31:0]         r_wr_data;
  logic [4:0]          r_alu_op;
  logic                r_alu_unsign;
  logic [31:0]         r_alu_mem_data;
  logic [31:0]         r_alu_st_data;
  logic [NT-1:0]       r_rsp_valid;
  logic [31:0]         r_rsp_data;
  logic                r_rsp_err;
  logic [NT-1:0]       r_resv_vld;
  logic [NT-1:0][29:0] r_resv_addr;

  logic                w_gnt_found;
  logic [TW-1:0]       w_gnt_tid;
  logic [NT-1:0]       w_gnt_onehot;
  logic [NT-1:0]       w_tid_onehot;
  logic [TW-1:0]       w_rr_next;
  logic                w_sc_pass;
  logic [4:0]          w_alu_op;

  // Grant = first valid thread at or after the round-robin pointer.
  always_comb begin
    int idx;
    idx          = 0;
    w_gnt_found  = 1'b0;
    w_gnt_tid    = '0;
    w_gnt_onehot = '0;
    for (int k = 0; k < NT; k++) begin
      idx = (int'(r_rr) + k) % NT;
      if (!w_gnt_found && bus.req_valid[idx]) begin
        w_gnt_found       = 1'b1;
        w_gnt_tid         = TW'(idx);
        w_gnt_onehot[idx] = 1'b1;
      end
    end
    for (int t = 0; t < NT; t++) w_tid_onehot[t] = (TW'(t) == r_tid);
  end

  assign w_rr_next = (w_gnt_tid == TW'(NT - 1)) ? '0 : w_gnt_tid + TW'(1);
  assign w_sc_pass = r_resv_vld[w_gnt_tid] &&
                     (r_resv_addr[w_gnt_tid] == bus.req_addr[w_gnt_tid][31:2]);

  always_comb begin
    unique case (r_op)
      5'd0, 5'd1, 5'd4, 5'd8, 5'd12, 5'd16, 5'd20, 5'd24, 5'd28: w_alu_op = r_op;
      default: w_alu_op = OP_SWAP;
    endcase
  end

  // A request is taken in the cycle req_valid[t] & req_ready[t] is high. Only IDLE accepts;
  // with contenders present, ready is raised only for the granted thread so a losing thread
  // never sees a completed handshake. With no requests pending every thread sees ready=1.
  assign bus.req_ready = (r_state != S_IDLE) ? '0 :
                         ((|bus.req_valid) ? w_gnt_onehot : '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_rr           <= '0;
      r_tid          <= '0;
      r_addr         <= '0;
      r_op           <= '0;
      r_unsign       <= 1'b0;
      r_data         <= '0;
      r_rd_data      <= '0;
      r_mem_rd_req   <= 1'b0;
      r_mem_wr_req   <= 1'b0;
      r_wr_data      <= '0;
      r_alu_op       <= '0;
      r_alu_unsign   <= 1'b0;
      r_alu_mem_data <= '0;
      r_alu_st_data  <= '0;
      r_rsp_valid    <= '0;
      r_rsp_data     <= '0;
      r_rsp_err      <= 1'b0;
      r_resv_vld     <= '0;
      r_resv_addr    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_gnt_found) begin
          r_tid    <= w_gnt_tid;
          r_rr     <= w_rr_next;
          r_addr   <= {bus.req_addr[w_gnt_tid][31:2], 2'b00};
          r_op     <= bus.req_op[w_gnt_tid];
          r_unsign <= bus.req_unsign[w_gnt_tid];
          r_data   <= bus.req_data[w_gnt_tid];
          if (bus.req_op[w_gnt_tid] == OP_SC) begin
            r_resv_vld[w_gnt_tid] <= 1'b0;
            if (w_sc_pass) begin
              r_wr_data    <= bus.req_data[w_gnt_tid];
              r_mem_wr_req <= 1'b1;
              r_state      <= S_WR;
            end else begin
              r_rsp_valid <= w_gnt_onehot;
              r_rsp_data  <= 32'd1;
              r_state     <= S_RSP;
            end
          end else begin
            r_mem_rd_req <= 1'b1;
            r_state      <= S_RD;
          end
        end
        S_RD: begin
          r_mem_rd_req <= 1'b0;
          r_state      <= S_WAIT;
        end
        S_WAIT: if (bus.mem_rd_valid) begin
          r_rd_data <= bus.mem_rd_data;
          if (bus.mem_rd_err) begin
            r_rsp_valid <= w_tid_onehot;
            r_rsp_err   <= 1'b1;
            r_rsp_data  <= '0;
            r_state     <= S_RSP;
          end else if (r_op == OP_LR) begin
            r_resv_vld[r_tid]  <= 1'b1;
            r_resv_addr[r_tid] <= r_addr[31:2];
            r_rsp_valid        <= w_tid_onehot;
            r_rsp_data         <= bus.mem_rd_data;
            r_state            <= S_RSP;
          end else begin
            r_alu_op       <= w_alu_op;
            r_alu_unsign   <= r_unsign;
            r_alu_mem_data <= bus.mem_rd_data;
            r_alu_st_data  <= r_data;
            r_state        <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_wr_data      <= bus.alu_result;
          r_mem_wr_req   <= 1'b1;
          r_alu_op       <= '0;
          r_alu_unsign   <= 1'b0;
          r_alu_mem_data <= '0;
          r_alu_st_data  <= '0;
          r_state        <= S_WR;
        end
        S_WR: if (bus.mem_wr_ack) begin
          r_mem_wr_req <= 1'b0;
          for (int t = 0; t < NT; t++)
            if (r_resv_addr[t] == r_addr[31:2]) r_resv_vld[t] <= 1'b0;
          r_rsp_valid <= w_tid_onehot;
          r_rsp_data  <= (r_op == OP_SC) ? 32'd0 : r_rd_data;
          r_state     <= S_RSP;
        end
        S_RSP: begin
          r_rsp_valid <= '0;
          r_rsp_data  <= '0;
          r_rsp_err   <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      // Placed after the FSM so a same-cycle snoop beats an LR reservation set.
      for (int t = 0; t < NT; t++)
        if (bus.snoop_wr_valid && (r_resv_addr[t] == bus.snoop_wr_addr[31:2]))
          r_resv_vld[t] <= 1'b0;
    end
  end

  assign bus.mem_rd_req   = r_mem_rd_req;
  assign bus.mem_addr     = r_addr;
  assign bus.mem_wr_req   = r_mem_wr_req;
  assign bus.mem_wr_data  = r_wr_data;
  assign bus.alu_op       = r_alu_op;
  assign bus.alu_unsign   = r_alu_unsign;
  assign bus.alu_mem_data = r_alu_mem_data;
  assign bus.alu_st_data  = r_alu_st_data;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_data     = r_rsp_data;
  assign bus.rsp_err      = r_rsp_err;
  assign bus.busy         = (r_state != S_IDLE);
  assign o_dbg_state      = r_state;
endmodule

// File: tb/tb_eh2_lsu_amo_ctl.sv
// Bench for eh2_lsu_amo_ctl: directed LR/SC/AMO transactions against a small memory and ALU
// model, with a response/write scoreboard checked by an independent monitor.
module tb_eh2_lsu_amo_ctl;
  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;
  int         cyc;
  int         n_chk;
  int         n_fail;

  eh2_lsu_amo_ctl_if #(.NT(2)) bus ();

  eh2_lsu_amo_ctl #(.NUM_THREADS(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [38:0] exp_q[$];     // {latency[3:0], err, tid_onehot[1:0], data[31:0]}
  logic [63:0] exp_wr_q[$];  // {addr, data}
  int          acc_q[$];
  logic [31:0] mem [0:1023];
  bit          rd_pend;
  bit          rd_err_inject;
  bit          ack_hold;
  int          wr_delay;
  int          wr_cnt;

  task automatic note_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: expected event did not occur (t=%0t)", name, $time);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- AMO ALU stand-in ----------------
  always_comb begin
    logic lt;
    lt = bus.alu_unsign ? (bus.alu_mem_data < bus.alu_st_data)
                        : ($signed(bus.alu_mem_data) < $signed(bus.alu_st_data));
    case (bus.alu_op)
      5'd0:         bus.alu_result = bus.alu_mem_data + bus.alu_st_data;
      5'd1:         bus.alu_result = bus.alu_st_data;
      5'd4:         bus.alu_result = bus.alu_mem_data ^ bus.alu_st_data;
      5'd8:         bus.alu_result = bus.alu_mem_data | bus.alu_st_data;
      5'd12:        bus.alu_result = bus.alu_mem_data & bus.alu_st_data;
      5'd16, 5'd24: bus.alu_result = lt ? bus.alu_mem_data : bus.alu_st_data;
      5'd20, 5'd28: bus.alu_result = lt ? bus.alu_st_data : bus.alu_mem_data;
      default:      bus.alu_result = 32'hDEAD_BEEF;
    endcase
  end

  // ---------------- memory responder ----------------
  initial begin
    rd_pend = 1'b0;
    wr_cnt  = 0;
    forever begin
      @(posedge clk); #1;
      bus.mem_rd_valid = 1'b0;
      bus.mem_rd_err   = 1'b0;
      bus.mem_rd_data  = '0;
      bus.mem_wr_ack   = 1'b0;
      if (rd_pend) begin
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = mem[bus.mem_addr[11:2]];
        bus.mem_rd_err   = rd_err_inject;
        rd_err_inject    = 1'b0;
        rd_pend          = 1'b0;
      end
      if (bus.mem_rd_req) rd_pend = 1'b1;
      if (bus.mem_wr_req && !ack_hold) begin
        if (wr_cnt >= wr_delay) begin
          bus.mem_wr_ack = 1'b1;
          wr_cnt         = 0;
        end else wr_cnt++;
      end else wr_cnt = 0;
    end
  end

  // ---------------- monitor ----------------
  logic [38:0] m_e;
  logic [63:0] m_w;
  int          m_acc;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        acc_q.delete();
      end else begin
        for (int t = 0; t < 2; t++)
          if (bus.req_valid[t] && bus.req_ready[t]) acc_q.push_back(cyc);
        if (|bus.rsp_valid) begin
          if (exp_q.size() == 0) note_fail("unexpected_rsp");
          else begin
            m_e = exp_q.pop_front();
            chk("rsp_tid", 64'(bus.rsp_valid), 64'(m_e[33:32]));
            chk("rsp_data", 64'(bus.rsp_data), 64'(m_e[31:0]));
            chk("rsp_err", 64'(bus.rsp_err), 64'(m_e[34]));
            if (acc_q.size() == 0) note_fail("rsp_without_accept");
            else begin
              m_acc = acc_q.pop_front();
              chk("rsp_latency", 64'(cyc - m_acc + 1), 64'(m_e[38:35]));
            end
          end
        end
        if (bus.mem_wr_req && bus.mem_wr_ack) begin
          if (exp_wr_q.size() == 0) note_fail("unexpected_write");
          else begin
            m_w = exp_wr_q.pop_front();
            chk("wr_addr", 64'(bus.mem_addr), 64'(m_w[63:32]));
            chk("wr_data", 64'(bus.mem_wr_data), 64'(m_w[31:0]));
          end
          mem[bus.mem_addr[11:2]] = bus.mem_wr_data;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(input int t, input logic [31:0] d, input logic e, input int lat);
    logic [1:0] oh;
    oh = 2'b01 << t;
    exp_q.push_back({4'(lat), e, oh, d});
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    exp_wr_q.push_back({wa, d});
  endtask

  // Entered and left at #1 after a rising edge.
  task automatic drive(input int t, input logic [31:0] a, input logic [4:0] op,
                       input logic u, input logic [31:0] d);
    int n;
    bit acc;
    n   = 0;
    acc = 1'b0;
    bus.req_valid[t]  = 1'b1;
    bus.req_addr[t]   = a;
    bus.req_op[t]     = op;
    bus.req_unsign[t] = u;
    bus.req_data[t]   = d;
    while (!acc && n < 100) begin
      @(negedge clk);
      if (bus.req_valid[t] && bus.req_ready[t]) acc = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    bus.req_valid[t] = 1'b0;
    if (!acc) note_fail("accept_timeout");
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_wr_q.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      note_fail("drain_timeout");
      exp_q.delete();
      exp_wr_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic txn(input int t, input logic [31:0] a, input logic [4:0] op, input logic u,
                     input logic [31:0] d, input logic [31:0] ersp, input logic eerr,
                     input int elat, input bit ewr, input logic [31:0] ewd);
    push_exp(t, ersp, eerr, elat);
    if (ewr) push_wr(a, ewd);
    drive(t, a, op, u, d);
    wait_idle();
  endtask

  task automatic snoop(input logic [31:0] a);
    bus.snoop_wr_valid = 1'b1;
    bus.snoop_wr_addr  = a;
    @(posedge clk); #1;
    bus.snoop_wr_valid = 1'b0;
    bus.snoop_wr_addr  = '0;
  endtask

  // ---------------- global watchdog ----------------
  initial begin
    #300000;
    note_fail("global_timeout");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    cyc    = 0;
    n_chk  = 0;
    n_fail = 0;
    rd_err_inject = 1'b0;
    ack_hold      = 1'b0;
    wr_delay      = 0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_op    = '0;
    bus.req_unsign = '0;
    bus.req_data  = '0;
    bus.snoop_wr_valid = 1'b0;
    bus.snoop_wr_addr  = '0;
    bus.mem_rd_valid = 1'b0;
    bus.mem_rd_err   = 1'b0;
    bus.mem_rd_data  = '0;
    bus.mem_wr_ack   = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[32'h100 >> 2] = 32'd5;
    mem[32'h104 >> 2] = 32'hFFFF_FFFF;
    mem[32'h108 >> 2] = 32'hFFFF_FFFF;
    mem[32'h110 >> 2] = 32'h10;
    mem[32'h114 >> 2] = 32'hF0;
    mem[32'h124 >> 2] = 32'd100;
    mem[32'h200 >> 2] = 32'h55;
    mem[32'h300 >> 2] = 32'hAB;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 64'(bus.req_ready), 64'h3);
    chk("reset_busy", 64'(bus.busy), 64'h0);
    chk("reset_rd_req", 64'(bus.mem_rd_req), 64'h0);
    chk("reset_wr_req", 64'(bus.mem_wr_req), 64'h0);
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("reset_alu_op", 64'(bus.alu_op), 64'h0);
    chk("reset_mem_addr", 64'(bus.mem_addr), 64'h0);
    chk("reset_state", 64'(dbg_state), 64'h0);
    rst = 1'b0;

    // amoadd / amomin / amominu
    txn(0, 32'h100, 5'd0,  1'b0, 32'd3, 32'd5,         1'b0, 6, 1'b1, 32'd8);
    txn(0, 32'h104, 5'd16, 1'b0, 32'd1, 32'hFFFF_FFFF, 1'b0, 6, 1'b1, 32'hFFFF_FFFF);
    txn(1, 32'h108, 5'd24, 1'b1, 32'd1, 32'hFFFF_FFFF, 1'b0, 6, 1'b1, 32'd1);

    // LR, SC pass, repeated SC fails
    txn(0, 32'h200, 5'd2, 1'b0, 32'd0, 32'h55, 1'b0, 4, 1'b0, 32'd0);
    txn(0, 32'h200, 5'd3, 1'b0, 32'd7, 32'd0,  1'b0, 3, 1'b1, 32'd7);
    txn(0, 32'h200, 5'd3, 1'b0, 32'd8, 32'd1,  1'b0, 2, 1'b0, 32'd0);

    // snoop kills reservation
    txn(0, 32'h200, 5'd2, 1'b0, 32'd0, 32'd7, 1'b0, 4, 1'b0, 32'd0);
    snoop(32'h200);
    txn(0, 32'h200, 5'd3, 1'b0, 32'd9, 32'd1, 1'b0, 2, 1'b0, 32'd0);

    // other thread's amoswap kills reservation
    txn(0, 32'h200, 5'd2, 1'b0, 32'd0,      32'd7, 1'b0, 4, 1'b0, 32'd0);
    txn(1, 32'h200, 5'd1, 1'b0, 32'h1234,   32'd7, 1'b0, 6, 1'b1, 32'h1234);
    txn(0, 32'h200, 5'd3, 1'b0, 32'd9,      32'd1, 1'b0, 2, 1'b0, 32'd0);

    // neighbouring-word snoop keeps reservation; byte offset ignored on SC
    txn(1, 32'h300, 5'd2, 1'b0, 32'd0,  32'hAB, 1'b0, 4, 1'b0, 32'd0);
    snoop(32'h304);
    txn(1, 32'h302, 5'd3, 1'b0, 32'h11, 32'd0,  1'b0, 3, 1'b1, 32'h11);

    // unknown opcode behaves as swap; write ack delayed two cycles
    wr_delay = 2;
    txn(0, 32'h110, 5'd5, 1'b0, 32'h77, 32'h10, 1'b0, 8, 1'b1, 32'h77);
    wr_delay = 0;

    // read error on amoor
    rd_err_inject = 1'b1;
    txn(1, 32'h114, 5'd8, 1'b0, 32'h0F, 32'd0, 1'b1, 4, 1'b0, 32'd0);

    // both threads contending: grants alternate T0,T1,T0,T1,T0
    push_exp(0, 32'd0,   1'b0, 6); push_wr(32'h120, 32'd1);
    push_exp(1, 32'd100, 1'b0, 6); push_wr(32'h124, 32'd110);
    push_exp(0, 32'd1,   1'b0, 6); push_wr(32'h120, 32'd2);
    push_exp(1, 32'd110, 1'b0, 6); push_wr(32'h124, 32'd120);
    push_exp(0, 32'd2,   1'b0, 6); push_wr(32'h120, 32'd3);
    fork
      begin
        for (int i = 0; i < 3; i++) drive(0, 32'h120, 5'd0, 1'b0, 32'd1);
      end
      begin
        for (int i = 0; i < 2; i++) drive(1, 32'h124, 5'd0, 1'b0, 32'd10);
      end
    join
    wait_idle();

    // reservation for T1, then reset during a pending write
    txn(1, 32'h300, 5'd2, 1'b0, 32'd0, 32'h11, 1'b0, 4, 1'b0, 32'd0);
    ack_hold = 1'b1;
    drive(0, 32'h130, 5'd0, 1'b0, 32'd1);
    chk("busy_ready_low", 64'(bus.req_ready), 64'h0);
    chk("busy_high", 64'(bus.busy), 64'h1);
    n = 0;
    while (!bus.mem_wr_req && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) note_fail("wr_req_wait");
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_wr_req", 64'(bus.mem_wr_req), 64'h0);
    chk("abort_busy", 64'(bus.busy), 64'h0);
    chk("abort_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    rst = 1'b0;
    ack_hold = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("abort_no_rsp_queued", 64'(exp_q.size()), 64'h0);
    txn(1, 32'h300, 5'd3, 1'b0, 32'h22, 32'd1, 1'b0, 2, 1'b0, 32'd0);

    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("final_exp_q_empty", 64'(exp_q.size()), 64'h0);
    chk("final_exp_wr_q_empty", 64'(exp_wr_q.size()), 64'h0);
    chk("final_mem_120", 64'(mem[32'h120 >> 2]), 64'h3);
    chk("final_mem_130", 64'(mem[32'h130 >> 2]), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
